// File: rtl/rgb_block_collector.sv
// Collects 64-pixel RGB blocks into ping-pong banks and presents each complete
// block as packed r_all/g_all/b_all buses under a valid/ready handshake.
module rgb_block_collector #(
    parameter int INPUT_WIDTH = 8,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INPUT_WIDTH-1:0]    in_r,
    input  logic [INPUT_WIDTH-1:0]    in_g,
    input  logic [INPUT_WIDTH-1:0]    in_b,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [INPUT_WIDTH*64-1:0] r_all,
    output logic [INPUT_WIDTH*64-1:0] g_all,
    output logic [INPUT_WIDTH*64-1:0] b_all,
    output logic [CNT_WIDTH-1:0]      blk_cnt,
    output logic                      frame_err
);

    localparam int         BUS_W    = INPUT_WIDTH * 64;
    localparam logic [5:0] LAST_IDX = 6'd63;

    logic [BUS_W-1:0] r_bank [2];
    logic [BUS_W-1:0] g_bank [2];
    logic [BUS_W-1:0] b_bank [2];

    logic [1:0] full;
    logic [1:0] full_next;
    logic       wr_bank;
    logic       rd_bank;
    logic [5:0] wr_idx;
    logic       running;

    logic accept;
    logic take;
    logic idx_last;
    logic closing;

    // Both handshake qualifiers depend on registers only, so no path from
    // out_ready reaches in_ready.
    assign in_ready  = running & ~full[wr_bank];
    assign out_valid = full[rd_bank];

    assign accept   = in_valid & in_ready;
    assign take     = out_valid & out_ready;
    assign idx_last = (wr_idx == LAST_IDX);
    assign closing  = accept & idx_last;

    assign r_all = r_bank[rd_bank];
    assign g_all = g_bank[rd_bank];
    assign b_all = b_bank[rd_bank];

    // Closing targets an empty bank and release targets a full one, so the
    // two updates never collide and both apply in the same cycle.
    always_comb begin
        full_next = full;
        if (take) begin
            full_next[rd_bank] = 1'b0;
        end
        if (closing) begin
            full_next[wr_bank] = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_idx    <= '0;
            running   <= 1'b0;
            blk_cnt   <= '0;
            frame_err <= 1'b0;
        end else begin
            running   <= 1'b1;
            full      <= full_next;
            frame_err <= accept & (in_last != idx_last);
            if (accept) begin
                wr_idx <= wr_idx + 6'd1;
            end
            if (closing) begin
                wr_bank <= ~wr_bank;
            end
            if (take) begin
                rd_bank <= ~rd_bank;
                blk_cnt <= blk_cnt + CNT_WIDTH'(1);
            end
        end
    end

    // NOTE: bank storage is deliberately reset so buses read zero after reset
    // and a discarded partial block can never leak into a later one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                r_bank[b] <= '0;
                g_bank[b] <= '0;
                b_bank[b] <= '0;
            end
        end else if (accept) begin
            r_bank[wr_bank][int'(wr_idx)*INPUT_WIDTH +: INPUT_WIDTH] <= in_r;
            g_bank[wr_bank][int'(wr_idx)*INPUT_WIDTH +: INPUT_WIDTH] <= in_g;
            b_bank[wr_bank][int'(wr_idx)*INPUT_WIDTH +: INPUT_WIDTH] <= in_b;
        end
    end

endmodule

// File: tb/tb_rgb_block_collector.sv
// Directed bench for rgb_block_collector: table of block patterns plus
// hand-written backpressure, same-cycle, and mid-block reset sequences.
module tb_rgb_block_collector;

    localparam int W     = 8;
    localparam int CW    = 16;
    localparam int BUS_W = W * 64;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_r;
    logic [W-1:0]     in_g;
    logic [W-1:0]     in_b;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [BUS_W-1:0] r_all;
    logic [BUS_W-1:0] g_all;
    logic [BUS_W-1:0] b_all;
    logic [CW-1:0]    blk_cnt;
    logic             frame_err;

    rgb_block_collector #(.INPUT_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_r      (in_r),
        .in_g      (in_g),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r_all     (r_all),
        .g_all     (g_all),
        .b_all     (b_all),
        .blk_cnt   (blk_cnt),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One block stimulus plus its expected frame_err pulse count.
    // Pixel i: r = r0 + rs*i, g = g0 + i, b = b0 - i (all mod 256).
    typedef struct {
        logic [7:0] r0;
        logic [7:0] rs;
        logic [7:0] g0;
        logic [7:0] b0;
        int         last_pos;
        int         exp_errs;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_cnt  = 0;
    vec_t vecs [4];

    function automatic logic [23:0] pix(vec_t v, int i);
        logic [7:0] ii;
        ii = i[7:0];
        return {v.r0 + v.rs * ii, v.g0 + ii, v.b0 - ii};
    endfunction

    function automatic logic [BUS_W-1:0] exp_bus(vec_t v, int c);
        logic [BUS_W-1:0] bus;
        logic [23:0]      p;
        bus = '0;
        for (int i = 0; i < 64; i++) begin
            p = pix(v, i);
            case (c)
                0:       bus[i*W +: W] = p[23:16];
                1:       bus[i*W +: W] = p[15:8];
                default: bus[i*W +: W] = p[7:0];
            endcase
        end
        return bus;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bus(input string name, input logic [BUS_W-1:0] act,
                             input logic [BUS_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_block(input string name, input vec_t v);
        check_bus({name, "_r"}, r_all, exp_bus(v, 0));
        check_bus({name, "_g"}, g_all, exp_bus(v, 1));
        check_bus({name, "_b"}, b_all, exp_bus(v, 2));
    endtask

    // Offers one beat and holds it until accepted, bounded by a cycle budget.
    task automatic send_beat(input logic [23:0] p, input logic last);
        int waited;
        waited   = 0;
        in_r     = p[23:16];
        in_g     = p[15:8];
        in_b     = p[7:0];
        in_last  = last;
        in_valid = 1'b1;
        while (!in_ready && waited < 300) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1",
                     in_ready, waited);
        end else begin
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Streams a whole block with out_ready high and checks fill latency,
    // bus contents, counter step and frame_err pulse count.
    task automatic run_block(input vec_t v, input string name);
        int errs;
        errs      = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) check_bit({name, "_valid_early"}, out_valid, 1'b0);
            send_beat(pix(v, i), i == v.last_pos);
            errs += int'(frame_err);
        end
        check_bit({name, "_valid_fill"}, out_valid, 1'b1);
        check_block(name, v);
        check_int({name, "_cnt_hold"}, int'(blk_cnt), exp_cnt);
        step();
        exp_cnt++;
        errs += int'(frame_err);
        check_int({name, "_cnt_inc"}, int'(blk_cnt), exp_cnt);
        check_bit({name, "_valid_clear"}, out_valid, 1'b0);
        check_int({name, "_frame_errs"}, errs, v.exp_errs);
        out_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        bp0, bp1, sc0, sc1, rm0, rm1;
        int          acc, fe;
        logic [23:0] p;

        vecs[0] = '{8'h00, 8'h01, 8'h40, 8'hFF, 63, 0};
        vecs[1] = '{8'h10, 8'h03, 8'h80, 8'hC0, 10, 2};
        vecs[2] = '{8'hA5, 8'h07, 8'h01, 8'h3F, -1, 1};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 8'h80, 63, 0};
        bp0     = '{8'h20, 8'h01, 8'h11, 8'hEE, 63, 0};
        bp1     = '{8'h90, 8'h05, 8'h33, 8'h77, 63, 0};
        sc0     = '{8'h01, 8'h02, 8'h50, 8'hA0, 63, 0};
        sc1     = '{8'h7F, 8'h09, 8'hC3, 8'h5A, 63, 0};
        rm0     = '{8'hEE, 8'h01, 8'hEE, 8'hEE, 63, 0};
        rm1     = '{8'h05, 8'h0B, 8'h22, 8'hF0, 63, 0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_r      = '0;
        in_g      = '0;
        in_b      = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // Reset state and release
        repeat (3) step();
        check_bit("rst_in_ready", in_ready, 1'b0);
        check_bit("rst_out_valid", out_valid, 1'b0);
        check_bus("rst_r_all", r_all, '0);
        check_bus("rst_g_all", g_all, '0);
        check_bus("rst_b_all", b_all, '0);
        check_int("rst_blk_cnt", int'(blk_cnt), 0);
        check_bit("rst_frame_err", frame_err, 1'b0);
        rst_n = 1'b1;
        check_bit("release_in_ready_low", in_ready, 1'b0);
        step();
        check_bit("release_in_ready_high", in_ready, 1'b1);
        check_bit("release_out_valid", out_valid, 1'b0);

        // Table-driven blocks
        for (int k = 0; k < 4; k++) begin
            run_block(vecs[k], $sformatf("vec%0d", k));
        end

        // Backpressure: 200 offered beats, only two banks' worth accepted
        out_ready = 1'b0;
        acc       = 0;
        fe        = 0;
        for (int c = 0; c < 200; c++) begin
            p        = (acc < 64) ? pix(bp0, acc) : pix(bp1, acc - 64);
            in_r     = p[23:16];
            in_g     = p[15:8];
            in_b     = p[7:0];
            in_last  = ((acc % 64) == 63);
            in_valid = 1'b1;
            if (in_ready) acc++;
            if (c == 100) begin
                check_bit("bp_mid_valid", out_valid, 1'b1);
                check_block("bp_mid", bp0);
            end
            step();
            fe += int'(frame_err);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check_int("bp_accepted", acc, 128);
        check_bit("bp_in_ready", in_ready, 1'b0);
        check_bit("bp_out_valid", out_valid, 1'b1);
        check_block("bp_end", bp0);
        check_int("bp_frame_errs", fe, 0);
        out_ready = 1'b1;
        step();
        exp_cnt++;
        check_int("bp_cnt_first", int'(blk_cnt), exp_cnt);
        check_bit("bp_valid_second", out_valid, 1'b1);
        check_block("bp_second", bp1);
        check_bit("bp_in_ready_back", in_ready, 1'b1);
        step();
        exp_cnt++;
        check_int("bp_cnt_second", int'(blk_cnt), exp_cnt);
        check_bit("bp_valid_drained", out_valid, 1'b0);
        out_ready = 1'b0;

        // Same-cycle close of one bank and release of the other
        for (int i = 0; i < 64; i++) send_beat(pix(sc0, i), i == 63);
        for (int i = 0; i < 63; i++) send_beat(pix(sc1, i), 1'b0);
        check_bit("sc_pre_valid", out_valid, 1'b1);
        check_block("sc_pre", sc0);
        out_ready = 1'b1;
        send_beat(pix(sc1, 63), 1'b1);
        exp_cnt++;
        check_bit("sc_valid_held", out_valid, 1'b1);
        check_block("sc_post", sc1);
        check_int("sc_cnt", int'(blk_cnt), exp_cnt);
        check_bit("sc_in_ready", in_ready, 1'b1);
        step();
        exp_cnt++;
        check_bit("sc_valid_drained", out_valid, 1'b0);
        check_int("sc_cnt_second", int'(blk_cnt), exp_cnt);
        out_ready = 1'b0;

        // Reset in the middle of a block
        for (int i = 0; i < 30; i++) send_beat(pix(rm0, i), 1'b0);
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        check_bit("rm_in_ready", in_ready, 1'b0);
        check_bit("rm_out_valid", out_valid, 1'b0);
        check_int("rm_blk_cnt", int'(blk_cnt), 0);
        check_bus("rm_r_all", r_all, '0);
        step();
        step();
        rst_n = 1'b1;
        check_bit("rm_release_low", in_ready, 1'b0);
        step();
        check_bit("rm_release_high", in_ready, 1'b1);
        run_block(rm1, "rm_block");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
